// File: rtl/board_move_sequencer.sv
// board_move_sequencer: sequences one 2048 move over an external 16-cell board
// store. It clears the board, waits for a button edge, and then reads, merges and
// writes each line in turn. After that it spawns a tile and scans for win or lose.
//
// Ports:
//   Clk, Reset            system clock, asynchronous active-high reset
//   up/down/left/right    debounced level buttons; rising edges start a move in IDLE
//   cell_rd_addr/_data    board read port (address combinational, data one cycle later)
//   cell_wr_addr/_data/we board write port (registered, one cell per cycle)
//   busy                  high outside IDLE, WIN and LOSE
//   moved                 one-cycle pulse after the last line when any cell changed
//   q_win, q_lose         sticky game-over flags, cleared only by Reset
module board_move_sequencer #(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [10:0] WIN_CODE  = 11'h400
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  output logic [3:0]  cell_rd_addr,
  input  logic [10:0] cell_rd_data,
  output logic [3:0]  cell_wr_addr,
  output logic [10:0] cell_wr_data,
  output logic        cell_we,
  output logic        busy,
  output logic        moved,
  output logic        q_win,
  output logic        q_lose
);

  localparam logic [3:0] S_CLR   = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_RD    = 4'd2;
  localparam logic [3:0] S_MRG   = 4'd3;
  localparam logic [3:0] S_WR    = 4'd4;
  localparam logic [3:0] S_SPAWN = 4'd5;
  localparam logic [3:0] S_CHECK = 4'd6;
  localparam logic [3:0] S_WIN   = 4'd7;
  localparam logic [3:0] S_LOSE  = 4'd8;

  // Direction codes double as bit positions in the button vector.
  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  logic [3:0]       state_q,      state_d;
  logic [4:0]       cnt_q,        cnt_d;
  logic [1:0]       line_q,       line_d;
  logic [1:0]       dir_q,        dir_d;
  logic [3:0]       btn_prev_q,   btn_prev_d;
  logic [3:0][10:0] line_buf_q,   line_buf_d;
  logic             changed_q,    changed_d;
  logic [7:0]       lfsr_q,       lfsr_d;
  logic [3:0]       sp_start_q,   sp_start_d;
  logic [3:0]       sp_idx_q,     sp_idx_d;
  logic             any_empty_q,  any_empty_d;
  logic             any_pair_q,   any_pair_d;
  logic             any_win_q,    any_win_d;
  logic [10:0]      left_nb_q,    left_nb_d;
  logic [3:0][10:0] prev_row_q,   prev_row_d;
  logic [3:0]       wr_addr_q,    wr_addr_d;
  logic [10:0]      wr_data_q,    wr_data_d;
  logic             we_q,         we_d;
  logic             moved_q,      moved_d;
  logic             win_q,        win_d;
  logic             lose_q,       lose_d;

  logic [3:0]       btn_now;
  logic [3:0]       btn_edge;
  logic [3:0][10:0] merged;
  logic [3:0]       sp_addr;
  logic [3:0]       chk_idx;
  logic             empty_n, pair_n, win_n;

  // Cell address of element j (front first) of line k for a given direction.
  function automatic logic [3:0] line_addr(input logic [1:0] dir, input logic [1:0] k,
                                           input logic [1:0] j);
    case (dir)
      D_UP:    return {j, k};
      D_DOWN:  return {~j, k};
      D_LEFT:  return {k, j};
      default: return {k, ~j};
    endcase
  endfunction

  // Compact toward the front, then merge equal neighbours front-first. A merged
  // tile is skipped so it cannot take part in a second merge.
  function automatic logic [3:0][10:0] merge_line(input logic [3:0][10:0] b);
    logic [4:0][10:0] c;
    logic [3:0][10:0] o;
    logic [2:0]       n;
    logic             skip;
    c    = '0;
    o    = '0;
    n    = 3'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] != '0) begin
        c[n] = b[i];
        n    = n + 3'd1;
      end
    end
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (c[i] != '0) begin
        if (c[i+1] == c[i]) begin
          o[n[1:0]] = c[i] << 1;
          skip      = 1'b1;
        end else begin
          o[n[1:0]] = c[i];
        end
        n = n + 3'd1;
      end
    end
    return o;
  endfunction

  assign btn_now  = {right, left, down, up};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign merged   = merge_line(line_buf_q);
  assign sp_addr  = sp_start_q + sp_idx_q;
  // CHECK captures the cell addressed on the previous cycle.
  assign chk_idx  = cnt_q[3:0] - 4'd1;

  assign empty_n = any_empty_q | (cell_rd_data == '0);
  assign win_n   = any_win_q | (cell_rd_data == WIN_CODE);
  assign pair_n  = any_pair_q | ((cell_rd_data != '0) &&
                   (((chk_idx[1:0] != 2'd0) && (cell_rd_data == left_nb_q)) ||
                    ((chk_idx[3:2] != 2'd0) && (cell_rd_data == prev_row_q[chk_idx[1:0]]))));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    dir_d       = dir_q;
    btn_prev_d  = btn_now;
    line_buf_d  = line_buf_q;
    changed_d   = changed_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    sp_start_d  = sp_start_q;
    sp_idx_d    = sp_idx_q;
    any_empty_d = any_empty_q;
    any_pair_d  = any_pair_q;
    any_win_d   = any_win_q;
    left_nb_d   = left_nb_q;
    prev_row_d  = prev_row_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 1'b0;
    moved_d     = 1'b0;
    win_d       = win_q;
    lose_d      = lose_q;
    cell_rd_addr = 4'd0;

    case (state_q)
      S_CLR: begin
        we_d = 1'b1;
        if (cnt_q == 5'd16) begin
          wr_addr_d = 4'd0;
          wr_data_d = 11'h001;
          cnt_d     = 5'd0;
          state_d   = S_IDLE;
        end else begin
          wr_addr_d = cnt_q[3:0];
          wr_data_d = 11'h000;
          cnt_d     = cnt_q + 5'd1;
        end
      end

      S_IDLE: begin
        if (btn_edge != 4'd0) begin
          if (btn_edge[0])      dir_d = D_UP;
          else if (btn_edge[1]) dir_d = D_DOWN;
          else if (btn_edge[2]) dir_d = D_LEFT;
          else                  dir_d = D_RIGHT;
          state_d   = S_RD;
          cnt_d     = 5'd0;
          line_d    = 2'd0;
          changed_d = 1'b0;
        end
      end

      S_RD: begin
        if (cnt_q != 5'd4) cell_rd_addr = line_addr(dir_q, line_q, cnt_q[1:0]);
        if (cnt_q != 5'd0) line_buf_d[cnt_q[1:0] - 2'd1] = cell_rd_data;
        if (cnt_q == 5'd4) begin
          cnt_d   = 5'd0;
          state_d = S_MRG;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_MRG: begin
        line_buf_d = merged;
        if (merged != line_buf_q) changed_d = 1'b1;
        state_d = S_WR;
        cnt_d   = 5'd0;
      end

      S_WR: begin
        we_d      = 1'b1;
        wr_addr_d = line_addr(dir_q, line_q, cnt_q[1:0]);
        wr_data_d = line_buf_q[cnt_q[1:0]];
        if (cnt_q == 5'd3) begin
          cnt_d = 5'd0;
          if (line_q == 2'd3) begin
            moved_d = changed_q;
            state_d = changed_q ? S_SPAWN : S_CHECK;
          end else begin
            line_d  = line_q + 2'd1;
            state_d = S_RD;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      // cnt 0: pick start; 1: address a probe; 2: inspect it; 3: let the write land.
      S_SPAWN: begin
        case (cnt_q)
          5'd0: begin
            sp_start_d = lfsr_q[3:0];
            sp_idx_d   = 4'd0;
            cnt_d      = 5'd1;
          end
          5'd1: begin
            cell_rd_addr = sp_addr;
            cnt_d        = 5'd2;
          end
          5'd2: begin
            if (cell_rd_data == '0) begin
              we_d      = 1'b1;
              wr_addr_d = sp_addr;
              wr_data_d = 11'h001;
              cnt_d     = 5'd3;
            end else if (sp_idx_q == 4'hF) begin
              cnt_d   = 5'd0;
              state_d = S_CHECK;
            end else begin
              sp_idx_d = sp_idx_q + 4'd1;
              cnt_d    = 5'd1;
            end
          end
          default: begin
            cnt_d   = 5'd0;
            state_d = S_CHECK;
          end
        endcase
      end

      S_CHECK: begin
        if (cnt_q != 5'd16) cell_rd_addr = cnt_q[3:0];
        if (cnt_q != 5'd0) begin
          any_empty_d = empty_n;
          any_pair_d  = pair_n;
          any_win_d   = win_n;
          left_nb_d   = cell_rd_data;
          prev_row_d[chk_idx[1:0]] = cell_rd_data;
        end
        if (cnt_q == 5'd16) begin
          cnt_d       = 5'd0;
          any_empty_d = 1'b0;
          any_pair_d  = 1'b0;
          any_win_d   = 1'b0;
          if (win_n) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else if (!empty_n && !pair_n) begin
            lose_d  = 1'b1;
            state_d = S_LOSE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_WIN, S_LOSE: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_CLR;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_CLR;
      cnt_q       <= 5'd0;
      line_q      <= 2'd0;
      dir_q       <= 2'd0;
      btn_prev_q  <= 4'd0;
      line_buf_q  <= '0;
      changed_q   <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      sp_start_q  <= 4'd0;
      sp_idx_q    <= 4'd0;
      any_empty_q <= 1'b0;
      any_pair_q  <= 1'b0;
      any_win_q   <= 1'b0;
      left_nb_q   <= '0;
      prev_row_q  <= '0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= '0;
      we_q        <= 1'b0;
      moved_q     <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      dir_q       <= dir_d;
      btn_prev_q  <= btn_prev_d;
      line_buf_q  <= line_buf_d;
      changed_q   <= changed_d;
      lfsr_q      <= lfsr_d;
      sp_start_q  <= sp_start_d;
      sp_idx_q    <= sp_idx_d;
      any_empty_q <= any_empty_d;
      any_pair_q  <= any_pair_d;
      any_win_q   <= any_win_d;
      left_nb_q   <= left_nb_d;
      prev_row_q  <= prev_row_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      moved_q     <= moved_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign cell_wr_addr = wr_addr_q;
  assign cell_wr_data = wr_data_q;
  assign cell_we      = we_q;
  assign moved        = moved_q;
  assign q_win        = win_q;
  assign q_lose       = lose_q;
  assign busy         = !((state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE));

endmodule
